// File: rtl/robot_pkg.sv
// robot_pkg: shared definitions for the light-follower drive controller.
//   - wheel command codes (STOP/FWD/REV; 2'd3 is never produced)
//   - FSM state encoding, which is also what mode_state reports
//   - active-low seven-segment glyphs and the code-to-glyph decode
package robot_pkg;

  localparam logic [1:0] STOP = 2'd0;
  localparam logic [1:0] FWD  = 2'd1;
  localparam logic [1:0] REV  = 2'd2;

  typedef enum logic [1:0] {
    AUTO_TRACK  = 2'd0,
    AUTO_SEARCH = 2'd1,
    AUTO_HALT   = 2'd2,
    MANUAL      = 2'd3
  } mode_e;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] GLYPH_S = 7'b0010010;
  localparam logic [6:0] GLYPH_F = 7'b0001110;
  localparam logic [6:0] GLYPH_R = 7'b0101111;

  function automatic logic [6:0] wheel_glyph(input logic [1:0] code);
    case (code)
      FWD:     return GLYPH_F;
      REV:     return GLYPH_R;
      default: return GLYPH_S;
    endcase
  endfunction

endpackage

// File: rtl/robot_drive_ctrl_wheel_guard.sv
// wheel_guard: applied-code register for one wheel with a reversal guard.
//   A direct FWD<->REV request is not applied at once: the wheel is held at
//   STOP for GUARD_CYCLES cycles and then takes the requested direction.
//   If the request falls back to STOP or to the original direction while
//   the guard is running, the guard is dropped and the request applies on
//   the next edge. Every other change applies on the next edge.
// Ports:
//   clk    in   clock
//   reset  in   synchronous active-high reset (applied code -> STOP)
//   cmd    in   2  requested wheel code
//   code   out  2  applied (registered) wheel code
module wheel_guard
  import robot_pkg::*;
#(
  parameter int GUARD_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] cmd,
  output logic [1:0] code
);

  localparam int GW = $clog2(GUARD_CYCLES + 1);

  logic [GW-1:0] hold;    // remaining forced-STOP cycles, 0 = no guard
  logic [1:0]    target;  // direction the guard is leading to
  logic          reversal;

  assign reversal = ((code == FWD) && (cmd == REV)) ||
                    ((code == REV) && (cmd == FWD));

  always_ff @(posedge clk) begin
    if (reset) begin
      code   <= STOP;
      hold   <= '0;
      target <= STOP;
    end else if (hold != '0) begin
      if (cmd == target) begin
        hold <= hold - 1'b1;
        // last forced-STOP cycle: hand over to the new direction
        if (hold == GW'(1)) code <= cmd;
      end else begin
        // request went to STOP or back to the old direction: drop the guard
        code <= cmd;
        hold <= '0;
      end
    end else if (reversal) begin
      code   <= STOP;
      hold   <= GW'(GUARD_CYCLES);
      target <= cmd;
    end else begin
      code <= cmd;
    end
  end

endmodule

// File: rtl/robot_drive_ctrl.sv
// robot_drive_ctrl: two-sensor light follower with manual override.
//   Sensors are registered once and compared to steer the wheels. A dark
//   period escalates AUTO_TRACK -> AUTO_SEARCH (spin) -> AUTO_HALT. Key 0
//   toggles MANUAL mode, where keys 3/2 drive the left/right wheel and key 1
//   selects reverse. Each wheel passes through a reversal guard.
// Ports:
//   clk          in   clock
//   reset        in   synchronous active-high reset
//   sens_l       in   SENSOR_W  left light sensor (unsigned)
//   sens_r       in   SENSOR_W  right light sensor (unsigned)
//   key_n        in   4   active-low async keys: [3] left, [2] right,
//                         [1] reverse, [0] mode toggle
//   left_wheel   out  2   applied left wheel code
//   right_wheel  out  2   applied right wheel code
//   hex1         out  7   left wheel glyph (active-low)
//   hex0         out  7   right wheel glyph (active-low)
//   mode_state   out  2   current FSM state
module robot_drive_ctrl
  import robot_pkg::*;
#(
  parameter int SENSOR_W        = 3,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DARK_CYCLES     = 8,
  parameter int SEARCH_CYCLES   = 16,
  parameter int GUARD_CYCLES    = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SENSOR_W-1:0] sens_l,
  input  logic [SENSOR_W-1:0] sens_r,
  input  logic [3:0]          key_n,
  output logic [1:0]          left_wheel,
  output logic [1:0]          right_wheel,
  output logic [6:0]          hex1,
  output logic [6:0]          hex0,
  output logic [1:0]          mode_state
);

  localparam int NUM_KEYS   = 4;
  localparam int NUM_WHEELS = 2;   // index 1 = left, 0 = right
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DKW = $clog2(DARK_CYCLES + 1);
  localparam int SCW = $clog2(SEARCH_CYCLES + 1);

  // ---------------------------------------------------------------------
  // Sensor register
  // ---------------------------------------------------------------------
  logic [SENSOR_W-1:0] sl_q, sr_q;
  logic                dark;

  always_ff @(posedge clk) begin
    if (reset) begin
      sl_q <= '0;
      sr_q <= '0;
    end else begin
      sl_q <= sens_l;
      sr_q <= sens_r;
    end
  end

  assign dark = (sl_q == '0) && (sr_q == '0);

  // ---------------------------------------------------------------------
  // Key synchroniser and debouncers
  // ---------------------------------------------------------------------
  logic [NUM_KEYS-1:0] key_s1, key_s2, key_db;
  logic                mode_key_d;
  logic                mode_press;

  always_ff @(posedge clk) begin
    if (reset) begin
      key_s1 <= '1;
      key_s2 <= '1;
    end else begin
      key_s1 <= key_n;
      key_s2 <= key_s1;
    end
  end

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    logic [DBW-1:0] cnt;   // consecutive samples disagreeing with level
    logic           level;

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt   <= '0;
        level <= 1'b1;
      end else if (key_s2[k] == level) begin
        cnt <= '0;
      end else if (cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
        cnt   <= '0;
        level <= key_s2[k];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign key_db[k] = level;
  end

  // Press pulse on the debounced 1->0 edge of the mode key; it is high for
  // the cycle right after the level flips, so the mode changes one edge later.
  always_ff @(posedge clk) begin
    if (reset) mode_key_d <= 1'b1;
    else       mode_key_d <= key_db[0];
  end

  assign mode_press = mode_key_d & ~key_db[0];

  // ---------------------------------------------------------------------
  // Mode FSM with dark and search counters
  // ---------------------------------------------------------------------
  mode_e          state;
  logic [DKW-1:0] dark_cnt;
  logic [SCW-1:0] search_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= AUTO_TRACK;
      dark_cnt   <= '0;
      search_cnt <= '0;
    end else if (mode_press) begin
      state      <= (state == MANUAL) ? AUTO_TRACK : MANUAL;
      dark_cnt   <= '0;
      search_cnt <= '0;
    end else begin
      case (state)
        AUTO_TRACK: begin
          if (!dark) begin
            dark_cnt <= '0;
          end else if (dark_cnt == DKW'(DARK_CYCLES - 1)) begin
            // this dark cycle is number DARK_CYCLES
            state      <= AUTO_SEARCH;
            dark_cnt   <= '0;
            search_cnt <= '0;
          end else begin
            dark_cnt <= dark_cnt + 1'b1;
          end
        end
        AUTO_SEARCH: begin
          // returning light is checked first so it beats the timer
          if (!dark) begin
            state      <= AUTO_TRACK;
            search_cnt <= '0;
          end else if (search_cnt == SCW'(SEARCH_CYCLES - 1)) begin
            state      <= AUTO_HALT;
            search_cnt <= '0;
          end else begin
            search_cnt <= search_cnt + 1'b1;
          end
        end
        AUTO_HALT: begin
          if (!dark) state <= AUTO_TRACK;
        end
        default: ;
      endcase
    end
  end

  assign mode_state = state;

  // ---------------------------------------------------------------------
  // Wheel command
  // ---------------------------------------------------------------------
  function automatic logic [1:0] manual_code(input logic held_n,
                                             input logic rev_n);
    if (held_n) return STOP;
    return rev_n ? FWD : REV;
  endfunction

  logic [NUM_WHEELS-1:0][1:0] cmd;
  logic [NUM_WHEELS-1:0][1:0] code;

  always_comb begin
    cmd = '{STOP, STOP};
    case (state)
      AUTO_TRACK: begin
        if (sl_q > sr_q) begin
          cmd[0] = FWD;
        end else if (sl_q < sr_q) begin
          cmd[1] = FWD;
        end else if (!dark) begin
          cmd[1] = FWD;
          cmd[0] = FWD;
        end
      end
      AUTO_SEARCH: begin
        cmd[1] = REV;
        cmd[0] = FWD;
      end
      MANUAL: begin
        cmd[1] = manual_code(key_db[3], key_db[1]);
        cmd[0] = manual_code(key_db[2], key_db[1]);
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Per-wheel guard and display decode
  // ---------------------------------------------------------------------
  for (genvar w = 0; w < NUM_WHEELS; w++) begin : g_wheel
    wheel_guard #(
      .GUARD_CYCLES (GUARD_CYCLES)
    ) u_guard (
      .clk   (clk),
      .reset (reset),
      .cmd   (cmd[w]),
      .code  (code[w])
    );
  end

  assign left_wheel  = code[1];
  assign right_wheel = code[0];
  assign hex1        = wheel_glyph(code[1]);
  assign hex0        = wheel_glyph(code[0]);

endmodule

// File: tb/tb_robot_drive_ctrl.sv
// Testbench for robot_drive_ctrl: directed scenarios with fixed expected
// values, then randomized sensors/keys/resets checked every cycle against a
// behavioural model built from the operating rules.
module tb_robot_drive_ctrl;

  localparam int SW = 3, DB = 4, DK = 8, SC = 16, GC = 3;
  localparam int T_STOP = 0, T_FWD = 1, T_REV = 2;
  localparam int G_S = 7'b0010010, G_F = 7'b0001110, G_R = 7'b0101111;

  logic          clk = 1'b0;
  logic          reset;
  logic [SW-1:0] sens_l, sens_r;
  logic [3:0]    key_n;
  logic [1:0]    left_wheel, right_wheel, mode_state;
  logic [6:0]    hex1, hex0;

  robot_drive_ctrl #(
    .SENSOR_W        (SW),
    .DEBOUNCE_CYCLES (DB),
    .DARK_CYCLES     (DK),
    .SEARCH_CYCLES   (SC),
    .GUARD_CYCLES    (GC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sens_l      (sens_l),
    .sens_r      (sens_r),
    .key_n       (key_n),
    .left_wheel  (left_wheel),
    .right_wheel (right_wheel),
    .hex1        (hex1),
    .hex0        (hex0),
    .mode_state  (mode_state)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  int       m_sl, m_sr;          // sensors as last registered
  int       m_mode;              // 0 track, 1 search, 2 halt, 3 manual
  int       m_dark_run;          // dark samples seen in a row while tracking
  int       m_search_t;          // cycles spent spinning
  logic [3:0] kh [0:DB+1];       // key_n sampled at each edge, [0] newest
  bit [3:0] m_level;             // debounced key levels
  bit       m_prev0;             // mode-key level one edge earlier
  int       m_app  [2];          // applied code, [1] left, [0] right
  int       m_hold [2];          // forced-STOP cycles still owed
  int       m_tgt  [2];

  function automatic int glyph(input int c);
    if (c == T_FWD) return G_F;
    if (c == T_REV) return G_R;
    return G_S;
  endfunction

  function automatic int man_cmd(input bit held_n, input bit rev_n);
    if (held_n) return T_STOP;
    return rev_n ? T_FWD : T_REV;
  endfunction

  task automatic model_step();
    int cmd [2];
    bit dark, press, all_diff;
    if (reset) begin
      m_sl = 0; m_sr = 0; m_mode = 0; m_dark_run = 0; m_search_t = 0;
      for (int j = 0; j < DB + 2; j++) kh[j] = 4'hF;
      m_level = 4'hF; m_prev0 = 1'b1;
      for (int w = 0; w < 2; w++) begin m_app[w] = 0; m_hold[w] = 0; m_tgt[w] = 0; end
      return;
    end
    dark  = (m_sl == 0) && (m_sr == 0);
    press = m_prev0 && !m_level[0];

    cmd[0] = T_STOP; cmd[1] = T_STOP;
    case (m_mode)
      0: begin
        if (m_sl > m_sr)      cmd[0] = T_FWD;
        else if (m_sl < m_sr) cmd[1] = T_FWD;
        else if (!dark) begin cmd[0] = T_FWD; cmd[1] = T_FWD; end
      end
      1: begin cmd[1] = T_REV; cmd[0] = T_FWD; end
      3: begin
        cmd[1] = man_cmd(m_level[3], m_level[1]);
        cmd[0] = man_cmd(m_level[2], m_level[1]);
      end
      default: ;
    endcase

    for (int w = 0; w < 2; w++) begin
      if (m_hold[w] > 0) begin
        if (cmd[w] == m_tgt[w]) begin
          m_hold[w]--;
          m_app[w] = (m_hold[w] == 0) ? cmd[w] : T_STOP;
        end else begin
          m_hold[w] = 0;
          m_app[w]  = cmd[w];
        end
      end else if (m_app[w] != T_STOP && cmd[w] != T_STOP && cmd[w] != m_app[w]) begin
        m_app[w] = T_STOP; m_hold[w] = GC; m_tgt[w] = cmd[w];
      end else begin
        m_app[w] = cmd[w];
      end
    end

    if (press) begin
      m_mode = (m_mode == 3) ? 0 : 3;
      m_dark_run = 0; m_search_t = 0;
    end else if (m_mode == 0) begin
      if (dark) begin
        m_dark_run++;
        if (m_dark_run == DK) begin m_mode = 1; m_dark_run = 0; m_search_t = 0; end
      end else m_dark_run = 0;
    end else if (m_mode == 1) begin
      if (!dark) m_mode = 0;
      else begin
        m_search_t++;
        if (m_search_t == SC) m_mode = 2;
      end
    end else if (m_mode == 2) begin
      if (!dark) m_mode = 0;
    end

    // a key level flips once the last DB synchronised samples (taken two
    // edges late) all disagree with it
    m_prev0 = m_level[0];
    for (int j = DB + 1; j > 0; j--) kh[j] = kh[j-1];
    kh[0] = key_n;
    for (int k = 0; k < 4; k++) begin
      all_diff = 1'b1;
      for (int j = 2; j < DB + 2; j++) if (kh[j][k] == m_level[k]) all_diff = 1'b0;
      if (all_diff) m_level[k] = ~m_level[k];
    end

    m_sl = int'(sens_l);
    m_sr = int'(sens_r);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("model_left",  left_wheel,  m_app[1]);
    chk("model_right", right_wheel, m_app[0]);
    chk("model_hex1",  hex1, glyph(m_app[1]));
    chk("model_hex0",  hex0, glyph(m_app[0]));
    chk("model_mode",  mode_state, m_mode);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; key_n = 4'hF; sens_l = '0; sens_r = '0;
    tick(); tick();
    chk("rst_mode", mode_state, 0);
    chk("rst_left", left_wheel, T_STOP);
    chk("rst_hex1", hex1, G_S);
    chk("rst_hex0", hex0, G_S);

    reset = 1'b0; sens_l = 3'd5; sens_r = 3'd2;
    tick();
    chk("lat_right", right_wheel, T_STOP);
    tick();
    chk("trk_left",  left_wheel,  T_STOP);
    chk("trk_right", right_wheel, T_FWD);
    chk("trk_hex1",  hex1, G_S);
    chk("trk_hex0",  hex0, G_F);

    // dark -> search -> halt -> relight
    sens_l = '0; sens_r = '0;
    repeat (8) tick();
    chk("dark_wait", mode_state, 0);
    tick();
    chk("search_in", mode_state, 1);
    tick();
    chk("search_left", left_wheel, T_REV);
    chk("search_hex1", hex1, G_R);
    repeat (14) tick();
    chk("search_hold", mode_state, 1);
    tick();
    chk("halt_in", mode_state, 2);
    sens_r = 3'd1;
    tick(); tick();
    chk("relight_mode", mode_state, 0);
    tick();
    chk("relight_left", left_wheel, T_FWD);

    // one lit cycle restarts the dark count
    sens_l = '0; sens_r = '0;
    repeat (7) tick();
    sens_l = 3'd3; sens_r = 3'd3;
    tick();
    sens_l = '0; sens_r = '0;
    repeat (8) tick();
    chk("redark_wait", mode_state, 0);
    tick();
    chk("redark_search", mode_state, 1);
    sens_l = 3'd4; sens_r = 3'd4;
    tick(); tick();
    chk("back_track", mode_state, 0);

    // debounce: short pulse ignored, long press toggles mode
    key_n[0] = 1'b0; repeat (3) tick();
    key_n[0] = 1'b1; repeat (10) tick();
    chk("short_key", mode_state, 0);
    key_n[0] = 1'b0; repeat (6) tick();
    chk("key_wait", mode_state, 0);
    tick();
    chk("manual_in", mode_state, 3);
    repeat (3) tick();
    key_n[0] = 1'b1; repeat (8) tick();

    key_n[3] = 1'b0; repeat (6) tick();
    chk("lkey_wait", left_wheel, T_STOP);
    tick();
    chk("man_left", left_wheel, T_FWD);
    chk("man_hex1", hex1, G_F);

    // FWD -> REV passes through exactly GC STOP cycles
    key_n[1] = 1'b0; repeat (7) tick();
    chk("guard_a", left_wheel, T_STOP);
    repeat (2) tick();
    chk("guard_c", left_wheel, T_STOP);
    tick();
    chk("guard_rev", left_wheel, T_REV);

    // reset mid-guard (REV -> FWD guard running)
    key_n[1] = 1'b1; repeat (8) tick();
    chk("guard2_stop", left_wheel, T_STOP);
    reset = 1'b1; key_n = 4'hF;
    tick();
    chk("rstg_mode", mode_state, 0);
    chk("rstg_left", left_wheel, T_STOP);
    chk("rstg_hex1", hex1, G_S);
    reset = 1'b0;

    // reset mid-search
    sens_l = '0; sens_r = '0;
    repeat (12) tick();
    chk("s2_mode", mode_state, 1);
    reset = 1'b1;
    tick();
    chk("rsts_mode",  mode_state, 0);
    chk("rsts_left",  left_wheel, T_STOP);
    chk("rsts_right", right_wheel, T_STOP);
    chk("rsts_hex0",  hex0, G_S);
    reset = 1'b0;

    // randomized run against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        if ($urandom_range(0, 2) == 0) begin
          sens_l = '0; sens_r = '0;
        end else begin
          sens_l = 3'($urandom_range(0, 7));
          sens_r = 3'($urandom_range(0, 7));
        end
      end
      if ($urandom_range(0, 15) == 0) key_n[$urandom_range(0, 3)] ^= 1'b1;
      reset = ($urandom_range(0, 799) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/robot_drive_ctrl.md
# robot_drive_ctrl

Clocked, parametrised successor to the two-sensor light-follower robot controller. Compares two SENSOR_W-bit light sensors to steer two wheels and adds a manual mode driven by debounced push-keys. Adds a dark-search/halt state machine and a per-wheel reversal guard. Drives the two wheel command codes and the two HEX displays (F / S / r) on the board top level.

## Interface
Parameters:
- SENSOR_W, 3: width of each light sensor input.
- DEBOUNCE_CYCLES, 4: consecutive stable samples required to accept a key change (≥1).
- DARK_CYCLES, 8: consecutive dark cycles in AUTO_TRACK before entering AUTO_SEARCH (≥1).
- SEARCH_CYCLES, 16: cycles spent spinning in AUTO_SEARCH before AUTO_HALT (≥1).
- GUARD_CYCLES, 3: STOP cycles forced between FWD and REV on one wheel (≥1).

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- sens_l  in  SENSOR_W  left light sensor, unsigned.
- sens_r  in  SENSOR_W  right light sensor, unsigned.
- key_n  in  4  push-keys, active-low, asynchronous. [3] left wheel, [2] right wheel, [1] reverse modifier, [0] mode toggle.
- left_wheel  out  2  applied left wheel code.
- right_wheel  out  2  applied right wheel code.
- hex1  out  7  left wheel glyph, active-low segments.
- hex0  out  7  right wheel glyph, active-low segments.
- mode_state  out  2  current FSM state.

## Operation
- Wheel codes: STOP=2'd0, FWD=2'd1, REV=2'd2; 2'd3 is never driven.
- Glyphs: STOP→S 7'b0010010, FWD→F 7'b0001110, REV→r 7'b0101111. Each hex is a pure decode of the registered applied code for its wheel.
- Sensors are registered once; all decisions use the registered values.
  - dark = both registered sensors zero.
- Keys pass through a 2-flop synchroniser, then a per-key debouncer.
  - The debounced level flips only after DEBOUNCE_CYCLES consecutive synchronised samples differ from it.
  - press = debounced 1→0 transition; one-cycle pulse.
- FSM states (mode_state encoding): AUTO_TRACK=0, AUTO_SEARCH=1, AUTO_HALT=2, MANUAL=3.
- AUTO_TRACK:
  - sens_l>sens_r → left STOP, right FWD.
  - sens_l<sens_r → left FWD, right STOP.
  - Equal and not dark → both FWD.
  - Dark → both STOP and the saturating dark counter increments; a not-dark cycle clears it.
  - Dark counter reaches DARK_CYCLES → AUTO_SEARCH.
- AUTO_SEARCH:
  - Command is left REV, right FWD.
  - Not dark → AUTO_TRACK.
  - SEARCH_CYCLES cycles elapsed → AUTO_HALT.
- AUTO_HALT:
  - Both STOP.
  - Not dark → AUTO_TRACK.
- MANUAL:
  - Wheel X = FWD if its key is held, REV if its key and key[1] are held, otherwise STOP.
  - Sensors are ignored.
- Press on key[0]:
  - From any AUTO_* state → MANUAL.
  - From MANUAL → AUTO_TRACK.
  - Takes priority over every other transition in the same cycle.
  - Clears the dark and search counters.
- Reversal guard, per wheel:
  - If the command is the direct opposite of the applied code (FWD↔REV), the applied code goes to STOP for exactly GUARD_CYCLES cycles, then takes the current command.
  - If the command changes to STOP or the same direction during the guard, the guard aborts and the new code applies next cycle.
  - All other changes apply next cycle.

## Timing
- Reset values:
  - left_wheel=right_wheel=STOP.
  - hex1=hex0=S.
  - mode_state=AUTO_TRACK.
  - Debounced keys released (1).
  - All counters and guard timers 0.
- Reset mid-guard or mid-search aborts immediately; there is no residual STOP hold.
- Sensor change to wheel output: 2 cycles (sensor register, then guard/output register).
- Key edge to press pulse: 2 + DEBOUNCE_CYCLES cycles. The state change appears on mode_state one cycle after the press.
- Dark→search:
  - AUTO_SEARCH entered DARK_CYCLES cycles after the first dark registered sample.
  - A single not-dark cycle in between restarts the count.
- Light returning on the same cycle the search timer expires: AUTO_TRACK wins.
- hex outputs change in the same cycle as the wheel codes; they are combinational from the wheel registers.

## Structure
- Package robot_pkg holds:
  - Wheel code localparams STOP/FWD/REV.
  - FSM state encodings.
  - Glyph constants F/S/r.
  - Function wheel_glyph(code) returning the 7-bit glyph.
- Sub-module wheel_guard: one wheel's reversal guard and applied-code register, parameter GUARD_CYCLES, instantiated twice.
- Debouncer logic is inline (4-key generate loop).

## Test plan
- Reset held 2 cycles, then sens_l=5, sens_r=2 → mode_state=0; after 2 cycles left_wheel=STOP, right_wheel=FWD, hex1=7'b0010010, hex0=7'b0001110.
- Sensors 0/0 held → wheels STOP; AUTO_SEARCH after 8 cycles (left REV, hex1=7'b0101111); AUTO_HALT after 16 more; sens_r=1 → AUTO_TRACK, left FWD 2 cycles later.
- Dark for 7 cycles, 1 lit cycle, dark again → search entered only 8 cycles after re-darkening.
- key_n[0] low for 3 cycles → no mode change. Held low for 10 cycles → MANUAL at cycle 2+4+1. key_n[3] low → left FWD.
- MANUAL with left FWD, then key_n[1] low → left STOP for exactly 3 cycles, then REV. Releasing key_n[1] during the guard → FWD next cycle.
- Reset asserted mid-guard and mid-AUTO_SEARCH → all outputs at reset values on the next edge.
